// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus: TXDATA/STATUS/BAUD_DIV/CTRL
// registers in a 4-word window, a byte FIFO, and a serialiser with a per-frame divider.
module mmio_uart_tx #(
   parameter int                    ADDR_WIDTH  = 12,
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 12'h400,
   parameter int                    FIFO_DEPTH  = 8,
   parameter logic [15:0]           DEFAULT_DIV = 16'd868
) (
   input  logic                  sysclk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [3:0]            byte_w_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  tx,
   output logic                  irq
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              mem_q [FIFO_DEPTH];
   logic [7:0]              mem_d [FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    ovf_q, ovf_d;
   logic [15:0]             baud_q, baud_d;
   logic                    tx_en_q, tx_en_d;
   logic [15:0]             div_l_q, div_l_d;
   logic [15:0]             cyc_cnt_q, cyc_cnt_d;
   logic [2:0]              bit_cnt_q, bit_cnt_d;
   logic [7:0]              shift_q, shift_d;
   logic                    tx_q, tx_d;
   logic                    irq_q, irq_d;
   logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;

   logic                    sel_s;
   logic [1:0]              reg_sel_s;
   logic                    wr_s;
   logic                    push_req_s;
   logic                    push_ok_s;
   logic                    sts_clr_s;
   logic                    full_s;
   logic                    empty_s;
   logic                    frame_avail_s;
   logic                    bit_end_s;
   logic                    pop_s;
   logic [15:0]             eff_div_s;
   logic [7:0]              count8_s;
   logic [DATA_WIDTH-1:0]   status_s;
   logic [DATA_WIDTH-1:0]   rd_val_s;

   // Bus decode and FIFO status flags.
   always_comb begin
      sel_s         = (addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
      reg_sel_s     = addr[1:0];
      wr_s          = |byte_w_en;
      full_s        = (count_q == FULL_CNT);
      empty_s       = (count_q == {CW{1'b0}});
      push_req_s    = sel_s && wr_s && (reg_sel_s == 2'd0) && byte_w_en[0];
      push_ok_s     = push_req_s && !full_s;
      sts_clr_s     = sel_s && (reg_sel_s == 2'd1) && byte_w_en[0] && wr_data[3];
      frame_avail_s = tx_en_q && !empty_s;
      bit_end_s     = (cyc_cnt_q == (div_l_q - 16'd1));
      eff_div_s     = (baud_q == 16'd0) ? 16'd1 : baud_q;
   end

   // FSM state register.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; STOP chains straight into START when more data is queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (frame_avail_s) state_d = S_START;
            else               state_d = S_IDLE;
         end
         S_START: begin
            if (bit_end_s) state_d = S_DATA;
            else           state_d = S_START;
         end
         S_DATA: begin
            if (bit_end_s && (bit_cnt_q == 3'd7)) state_d = S_STOP;
            else                                  state_d = S_DATA;
         end
         S_STOP: begin
            if (bit_end_s && frame_avail_s) state_d = S_START;
            else if (bit_end_s)             state_d = S_IDLE;
            else                            state_d = S_STOP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: FIFO pop request and the next serial line level.
   always_comb begin
      pop_s = 1'b0;
      tx_d  = 1'b1;
      case (state_q)
         S_IDLE: begin
            pop_s = frame_avail_s;
            tx_d  = 1'b1;
         end
         S_START: begin
            pop_s = 1'b0;
            tx_d  = 1'b0;
         end
         S_DATA: begin
            pop_s = 1'b0;
            tx_d  = shift_q[0];
         end
         S_STOP: begin
            pop_s = bit_end_s && frame_avail_s;
            tx_d  = 1'b1;
         end
         default: begin
            pop_s = 1'b0;
            tx_d  = 1'b1;
         end
      endcase
   end

   // Bit timing, shift register and the per-frame divider latch.
   always_comb begin
      if (state_q == S_IDLE) begin
         cyc_cnt_d = 16'd0;
      end else if (bit_end_s) begin
         cyc_cnt_d = 16'd0;
      end else begin
         cyc_cnt_d = cyc_cnt_q + 16'd1;
      end

      if (state_q != S_DATA) begin
         bit_cnt_d = 3'd0;
      end else if (bit_end_s) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
      end else begin
         bit_cnt_d = bit_cnt_q;
      end

      if (pop_s) begin
         shift_d = mem_q[rd_ptr_q];
         div_l_d = eff_div_s;
      end else if ((state_q == S_DATA) && bit_end_s) begin
         shift_d = {1'b0, shift_q[7:1]};
         div_l_d = div_l_q;
      end else begin
         shift_d = shift_q;
         div_l_d = div_l_q;
      end
   end

   // FIFO storage, pointers and occupancy; a push into a full FIFO is dropped.
   always_comb begin
      mem_d = mem_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = wr_data[7:0];
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d        = wr_ptr_q;
      end

      if (pop_s) rd_ptr_d = rd_ptr_q + PW'(1);
      else       rd_ptr_d = rd_ptr_q;

      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Software-visible control registers and the sticky overflow flag.
   always_comb begin
      baud_d  = baud_q;
      tx_en_d = tx_en_q;
      if (sel_s && (reg_sel_s == 2'd2)) begin
         if (byte_w_en[0]) baud_d[7:0]  = wr_data[7:0];
         else              baud_d[7:0]  = baud_q[7:0];
         if (byte_w_en[1]) baud_d[15:8] = wr_data[15:8];
         else              baud_d[15:8] = baud_q[15:8];
      end else begin
         baud_d = baud_q;
      end

      if (sel_s && (reg_sel_s == 2'd3) && byte_w_en[0]) tx_en_d = wr_data[0];
      else                                              tx_en_d = tx_en_q;

      if (push_req_s && full_s) ovf_d = 1'b1;
      else if (sts_clr_s)       ovf_d = 1'b0;
      else                      ovf_d = ovf_q;

      irq_d = (count_d == {CW{1'b0}}) && (state_d == S_IDLE) && tx_en_d;
   end

   // Read mux; samples pre-edge state and holds when r_en is low.
   always_comb begin
      count8_s = 8'(count_q);
      status_s = {16'h0000, count8_s, 4'h0, ovf_q, (state_q != S_IDLE), empty_s, full_s};
      if (sel_s) begin
         case (reg_sel_s)
            2'd1:    rd_val_s = status_s;
            2'd2:    rd_val_s = {16'h0000, baud_q};
            2'd3:    rd_val_s = {31'h0000_0000, tx_en_q};
            default: rd_val_s = '0;
         endcase
      end else begin
         rd_val_s = '0;
      end

      if (r_en) r_data_d = rd_val_s;
      else      r_data_d = r_data_q;
   end

   // Datapath and register file flops.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         mem_q     <= '{default: 8'h00};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         baud_q    <= DEFAULT_DIV;
         tx_en_q   <= 1'b0;
         div_l_q   <= 16'd1;
         cyc_cnt_q <= 16'd0;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'h00;
         tx_q      <= 1'b1;
         irq_q     <= 1'b0;
         r_data_q  <= '0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         baud_q    <= baud_d;
         tx_en_q   <= tx_en_d;
         div_l_q   <= div_l_d;
         cyc_cnt_q <= cyc_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         irq_q     <= irq_d;
         r_data_q  <= r_data_d;
      end
   end

   assign tx     = tx_q;
   assign irq    = irq_q;
   assign r_data = r_data_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a line receiver recovers frames from tx and each scenario
// compares them against bytes and dividers tracked in bench-side queues.
module tb_mmio_uart_tx;

   localparam logic [11:0] A_TXDATA = 12'h400;
   localparam logic [11:0] A_STATUS = 12'h401;
   localparam logic [11:0] A_BAUD   = 12'h402;
   localparam logic [11:0] A_CTRL   = 12'h403;

   logic        sysclk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] addr = 12'h000;
   logic [3:0]  byte_w_en = 4'h0;
   logic [31:0] wr_data = 32'h0;
   logic        r_en = 1'b0;
   logic [31:0] r_data;
   logic        tx;
   logic        irq;

   int total = 0;
   int bad   = 0;

   mmio_uart_tx dut (
      .sysclk    (sysclk),
      .rst       (rst),
      .addr      (addr),
      .byte_w_en (byte_w_en),
      .wr_data   (wr_data),
      .r_en      (r_en),
      .r_data    (r_data),
      .tx        (tx),
      .irq       (irq)
   );

   always #5 sysclk = ~sysclk;

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic bus_write(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
      addr = a; byte_w_en = be; wr_data = d;
      tick();
      byte_w_en = 4'h0;
   endtask

   task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
      addr = a; r_en = 1'b1;
      tick();
      d = r_data;
      r_en = 1'b0;
   endtask

   // Receiver: waits (bounded) for a start edge, then samples each of the 10 bit slots
   // at its first cycle and counts cycles inside a slot that disagree with that level.
   task automatic capture(input int div, input int limit, output int waited,
                          output logic [9:0] slots, output int glitches);
      waited = -1; slots = '1; glitches = 0;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if (tx === 1'b0) begin
            waited = i;
            break;
         end
      end
      if (waited >= 0) begin
         for (int k = 0; k < 10 * div; k++) begin
            if (k != 0) tick();
            if (k % div == 0) slots[k / div] = tx;
            else if (tx !== slots[k / div]) glitches++;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      total++; if (r_data !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 00000000", r_data); end
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
      bus_read(A_STATUS, d);
      total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL reset_status: got %h want 00000002", d); end
      bus_read(A_BAUD, d);
      total++; if (d !== 32'd868) begin bad++; $display("FAIL reset_baud: got %0d want 868", d); end
      bus_read(A_CTRL, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h want 00000000", d); end
   endtask

   task automatic test_single_frame();
      int w, g;
      logic [9:0] s;
      do_reset();
      bus_write(A_BAUD, 4'h3, 32'd4);
      bus_write(A_CTRL, 4'h1, 32'd1);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL single_irq_idle: got %b want 1", irq); end
      bus_write(A_TXDATA, 4'h1, 32'h0000_00A5);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL single_irq_queued: got %b want 0", irq); end
      capture(4, 10, w, s, g);
      total++;
      if (w < 0 || s !== {1'b1, 8'hA5, 1'b0} || g != 0) begin
         bad++; $display("FAIL single_frame: got slots=%b glitches=%0d waited=%0d want slots=%b glitches=0", s, g, w, {1'b1, 8'hA5, 1'b0});
      end
      tick();
      total++; if (tx !== 1'b1 || irq !== 1'b1) begin bad++; $display("FAIL single_after: got tx=%b irq=%b want tx=1 irq=1", tx, irq); end
   endtask

   task automatic test_back_to_back();
      int w0, g0, w1, g1;
      logic [9:0] s0, s1;
      logic [31:0] d, st1, st2;
      do_reset();
      bus_write(A_BAUD, 4'h3, 32'd4);
      bus_write(A_TXDATA, 4'h1, 32'h55);
      bus_write(A_TXDATA, 4'h1, 32'h0F);
      bus_read(A_STATUS, d);
      total++; if (d !== 32'h0000_0200) begin bad++; $display("FAIL b2b_status2: got %h want 00000200", d); end
      bus_write(A_CTRL, 4'h1, 32'd1);
      fork
         begin
            capture(4, 10, w0, s0, g0);
            capture(4, 3, w1, s1, g1);
         end
         begin
            repeat (5) tick();
            bus_read(A_STATUS, st1);
            repeat (40) tick();
            bus_read(A_STATUS, st2);
         end
      join
      total++; if (w0 < 0 || s0 !== {1'b1, 8'h55, 1'b0} || g0 != 0) begin bad++; $display("FAIL b2b_frame0: got slots=%b glitches=%0d want %b", s0, g0, {1'b1, 8'h55, 1'b0}); end
      total++; if (w1 != 1 || s1 !== {1'b1, 8'h0F, 1'b0} || g1 != 0) begin bad++; $display("FAIL b2b_frame1: got slots=%b glitches=%0d gap=%0d want %b gap=1", s1, g1, w1, {1'b1, 8'h0F, 1'b0}); end
      total++; if (st1 !== 32'h0000_0104) begin bad++; $display("FAIL b2b_status1: got %h want 00000104", st1); end
      total++; if (st2 !== 32'h0000_0006) begin bad++; $display("FAIL b2b_status0: got %h want 00000006", st2); end
   endtask

   task automatic test_overflow();
      logic [7:0] q[$];
      logic [7:0] b;
      logic [31:0] d;
      int w, g;
      logic [9:0] s;
      do_reset();
      bus_write(A_BAUD, 4'h3, 32'd1);
      for (int i = 0; i < 9; i++) begin
         b = 8'($urandom);
         if (i < 8) q.push_back(b);
         bus_write(A_TXDATA, 4'h1, {24'h0, b});
      end
      bus_read(A_STATUS, d);
      total++; if (d !== 32'h0000_0809) begin bad++; $display("FAIL ovf_status: got %h want 00000809", d); end
      bus_write(A_STATUS, 4'h1, 32'h8);
      bus_read(A_STATUS, d);
      total++; if (d !== 32'h0000_0801) begin bad++; $display("FAIL ovf_clear: got %h want 00000801", d); end
      bus_write(A_CTRL, 4'h1, 32'd1);
      for (int i = 0; i < 8; i++) begin
         capture(1, (i == 0) ? 10 : 3, w, s, g);
         total++;
         if (w < 0 || (i > 0 && w != 1) || s !== {1'b1, q[i], 1'b0} || g != 0) begin
            bad++; $display("FAIL ovf_drain[%0d]: got slots=%b gap=%0d want %b", i, s, w, {1'b1, q[i], 1'b0});
         end
      end
      bus_read(A_STATUS, d);
      total++; if (d !== 32'h0000_0002 || irq !== 1'b1) begin bad++; $display("FAIL ovf_empty: got status=%h irq=%b want 00000002 irq=1", d, irq); end
   endtask

   task automatic test_divider_change();
      int w0, g0, w1, g1, w2, g2;
      logic [9:0] s0, s1, s2;
      logic [7:0] b0, b1, b2;
      do_reset();
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
      bus_write(A_BAUD, 4'h3, 32'd4);
      bus_write(A_TXDATA, 4'h1, {24'h0, b0});
      bus_write(A_TXDATA, 4'h1, {24'h0, b1});
      bus_write(A_CTRL, 4'h1, 32'd1);
      fork
         begin
            capture(4, 10, w0, s0, g0);
            capture(2, 3, w1, s1, g1);
         end
         begin
            repeat (12) tick();
            bus_write(A_BAUD, 4'h3, 32'd2);
         end
      join
      total++; if (w0 < 0 || s0 !== {1'b1, b0, 1'b0} || g0 != 0) begin bad++; $display("FAIL div_frame40: got slots=%b glitches=%0d want %b", s0, g0, {1'b1, b0, 1'b0}); end
      total++; if (w1 != 1 || s1 !== {1'b1, b1, 1'b0} || g1 != 0) begin bad++; $display("FAIL div_frame20: got slots=%b glitches=%0d gap=%0d want %b", s1, g1, w1, {1'b1, b1, 1'b0}); end
      tick();
      bus_write(A_BAUD, 4'h3, 32'd0);
      bus_write(A_TXDATA, 4'h1, {24'h0, b2});
      capture(1, 10, w2, s2, g2);
      total++; if (w2 < 0 || s2 !== {1'b1, b2, 1'b0} || g2 != 0) begin bad++; $display("FAIL div_zero: got slots=%b glitches=%0d want %b", s2, g2, {1'b1, b2, 1'b0}); end
      tick();
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL div_zero_end: got tx=%b want 1", tx); end
   endtask

   task automatic test_random();
      logic [7:0] q[$];
      logic [7:0] b;
      int div, n, w, g;
      logic [9:0] s;
      do_reset();
      bus_write(A_CTRL, 4'h1, 32'd1);
      for (int i = 0; i < 6; i++) begin
         div = $urandom_range(1, 6);
         b = 8'($urandom);
         bus_write(A_BAUD, 4'h3, div);
         bus_write(A_TXDATA, 4'h1, {24'h0, b});
         capture(div, 10, w, s, g);
         total++; if (w < 0 || s !== {1'b1, b, 1'b0} || g != 0) begin bad++; $display("FAIL rand_single[%0d]: got slots=%b glitches=%0d want %b div=%0d", i, s, g, {1'b1, b, 1'b0}, div); end
      end
      bus_write(A_CTRL, 4'h1, 32'd0);
      n = $urandom_range(2, 8);
      div = $urandom_range(1, 6);
      bus_write(A_BAUD, 4'h3, div);
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         q.push_back(b);
         bus_write(A_TXDATA, 4'h1, {24'h0, b});
      end
      bus_write(A_CTRL, 4'h1, 32'd1);
      for (int i = 0; i < n; i++) begin
         capture(div, (i == 0) ? 10 : 3, w, s, g);
         total++;
         if (w < 0 || (i > 0 && w != 1) || s !== {1'b1, q[i], 1'b0} || g != 0) begin
            bad++; $display("FAIL rand_burst[%0d]: got slots=%b gap=%0d glitches=%0d want %b", i, s, w, g, {1'b1, q[i], 1'b0});
         end
      end
   endtask

   task automatic test_reset_mid_frame_and_decode();
      logic [31:0] d;
      bit found;
      int ones;
      do_reset();
      bus_write(A_BAUD, 4'h3, 32'd4);
      bus_write(A_CTRL, 4'h1, 32'd1);
      bus_write(A_TXDATA, 4'h1, 32'h00);
      bus_write(A_TXDATA, 4'h1, 32'h00);
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tx === 1'b0) begin found = 1'b1; break; end
      end
      total++; if (!found) begin bad++; $display("FAIL rst_mid_start: got no start bit want start within 10 cycles"); end
      repeat (8) tick();
      rst = 1'b1;
      tick();
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
      rst = 1'b0;
      bus_read(A_STATUS, d);
      total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL rst_mid_status: got %h want 00000002", d); end
      ones = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (tx === 1'b1) ones++;
      end
      total++; if (ones != 60) begin bad++; $display("FAIL rst_mid_quiet: got %0d idle cycles want 60", ones); end
      bus_write(A_BAUD, 4'h1, 32'h1234_5678);
      bus_read(A_BAUD, d);
      total++; if (d !== 32'h0000_0378) begin bad++; $display("FAIL baud_bytelane: got %h want 00000378", d); end
      bus_write(12'h404, 4'hF, 32'hFFFF_FFFF);
      bus_write(12'h407, 4'hF, 32'h0000_0001);
      bus_write(12'h401, 4'h2, 32'h0000_0000);
      bus_read(A_STATUS, d);
      total++; if (d !== 32'h0000_0002 || irq !== 1'b0) begin bad++; $display("FAIL decode_nowrite: got status=%h irq=%b want 00000002 irq=0", d, irq); end
      bus_read(A_BAUD, d);
      addr = 12'h405;
      tick();
      total++; if (r_data !== 32'h0000_0378) begin bad++; $display("FAIL read_hold: got %h want 00000378", r_data); end
      bus_read(12'h405, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL decode_read: got %h want 00000000", d); end
      bus_read(A_BAUD, d);
      bus_read(A_TXDATA, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL txdata_read: got %h want 00000000", d); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow();
      test_divider_change();
      test_random();
      test_reset_mid_frame_and_decode();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
